// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV64I core: fetch/decode/exec/mem/write-back sequencing.
// Optional performance counters are enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  mem_rdata_op,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic [63:0] pc_init,
  output logic [2:0]  imm_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [63:0] perf_cycles,
  output logic [63:0] perf_instret
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;

  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_SB = 3'd2;
  localparam logic [2:0] IMM_U  = 3'd3;
  localparam logic [2:0] IMM_UJ = 3'd4;

  // Wait counter is at least 8 bits and widens for larger timeouts.
  localparam int CNT_W = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;

  state_t             state_q, state_d;
  logic [6:0]         opcode_q;
  logic [CNT_W-1:0]   wait_q, wait_inc;
  logic               illegal_q;

  function automatic logic [2:0] imm_type(input logic [6:0] op);
    case (op)
      OPC_STORE:          imm_type = IMM_S;
      OPC_BRANCH:         imm_type = IMM_SB;
      OPC_LUI, OPC_AUIPC: imm_type = IMM_U;
      OPC_JAL:            imm_type = IMM_UJ;
      default:            imm_type = IMM_I;
    endcase
  endfunction

  function automatic logic known_op(input logic [6:0] op);
    case (op)
      OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: known_op = 1'b1;
      default:                                known_op = 1'b0;
    endcase
  endfunction

  assign pc_init  = RESET_PC;
  assign wait_inc = wait_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    imm_sel      = IMM_I;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    illegal      = illegal_q;

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        imm_sel = imm_type(opcode_q);
        state_d = known_op(opcode_q) ? EXEC : TRAP;
      end
      EXEC: begin
        imm_sel = imm_type(opcode_q);
        state_d = WB;
        case (opcode_q)
          OPC_OPIMM, OPC_JALR: alu_b_sel = 1'b1;
          OPC_LOAD, OPC_STORE: begin
            alu_b_sel = 1'b1;
            state_d   = MEM;
          end
          OPC_AUIPC: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
          end
          OPC_BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = {1'b0, br_taken};
            state_d = FETCH;
          end
          OPC_OP, OPC_LUI, OPC_JAL: ;
          default: state_d = TRAP;
        endcase
      end
      MEM: begin
        imm_sel      = imm_type(opcode_q);
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode_q == OPC_STORE);
        if (mem_ready) begin
          if (opcode_q == OPC_STORE) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        imm_sel = imm_type(opcode_q);
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        case (opcode_q)
          OPC_LOAD: wb_sel = 2'd1;
          OPC_JAL: begin
            wb_sel = 2'd2;
            pc_src = 2'd1;
          end
          OPC_JALR: begin
            wb_sel = 2'd2;
            pc_src = 2'd2;
          end
          OPC_LUI:  wb_sel = 2'd3;
          default:  wb_sel = 2'd0;
        endcase
        state_d = FETCH;
      end
      default: state_d = TRAP;
    endcase

    // A stalled memory access that exhausts its budget abandons the instruction.
    if ((MEM_TIMEOUT != 0) && mem_req && !mem_ready && (wait_inc == CNT_W'(MEM_TIMEOUT)))
      state_d = TRAP;

    if (rst) begin
      imm_sel      = IMM_I;
      mem_req      = (state_q == FETCH);
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'd0;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = 2'd0;
      illegal      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      opcode_q  <= OPC_OPIMM;
      wait_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_we)
        opcode_q <= mem_rdata_op;
      if ((state_d != state_q) || mem_ready || !mem_req)
        wait_q <= '0;
      else
        wait_q <= wait_inc;
      if (state_d == TRAP)
        illegal_q <= 1'b1;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles  <= 64'd0;
      perf_instret <= 64'd0;
    end else begin
      if (state_q != TRAP)
        perf_cycles <= perf_cycles + 64'd1;
      if (pc_we)
        perf_instret <= perf_instret + 64'd1;
    end
  end
`endif

endmodule
